// File: rtl/cpu_ctrl_pkg.sv
// Shared control-path definitions: opcode values, control-word bit positions,
// sweep FSM states and the reference opcode -> control-word map.
package cpu_ctrl_pkg;

    localparam int CTRL_W = 7;

    localparam logic [2:0] OP_RTYPE = 3'd0;
    localparam logic [2:0] OP_ADDI  = 3'd1;
    localparam logic [2:0] OP_LW    = 3'd2;
    localparam logic [2:0] OP_SW    = 3'd3;
    localparam logic [2:0] OP_BEQ   = 3'd4;
    localparam logic [2:0] OP_JMP   = 3'd5;

    localparam int CW_MEM_TO_REG = 0;
    localparam int CW_REG_DST    = 1;
    localparam int CW_REG_WRITE  = 2;
    localparam int CW_ALU_SRC    = 3;
    localparam int CW_MEM_WRITE  = 4;
    localparam int CW_BRANCH     = 5;
    localparam int CW_JUMP       = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_NEXT,
        ST_DONE
    } sweep_state_e;

    // Reserved opcodes (110, 111) expect an all-zero word.
    function automatic logic [CTRL_W-1:0] expected_word(input logic [2:0] op);
        logic [CTRL_W-1:0] w;
        w = '0;
        case (op)
            OP_RTYPE: begin
                w[CW_REG_DST]   = 1'b1;
                w[CW_REG_WRITE] = 1'b1;
            end
            OP_ADDI: begin
                w[CW_ALU_SRC]   = 1'b1;
                w[CW_REG_WRITE] = 1'b1;
            end
            OP_LW: begin
                w[CW_ALU_SRC]    = 1'b1;
                w[CW_REG_WRITE]  = 1'b1;
                w[CW_MEM_TO_REG] = 1'b1;
            end
            OP_SW: begin
                w[CW_MEM_WRITE] = 1'b1;
                w[CW_ALU_SRC]   = 1'b1;
            end
            OP_BEQ:  w[CW_BRANCH] = 1'b1;
            OP_JMP:  w[CW_JUMP]   = 1'b1;
            default: w = '0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/ctrl_word_encoder.sv
// Combinational inverse of the control decoder: control word -> opcode.
// All-zero words map to 110 (reserved), unrecognised words to 111; both invalid.
module ctrl_word_encoder
    import cpu_ctrl_pkg::*;
(
    input  logic [CTRL_W-1:0] ctrl_word,
    output logic [2:0]        enc_opcode,
    output logic              enc_valid
);

    always_comb begin
        enc_opcode = 3'b111;
        enc_valid  = 1'b0;
        // Field order: {jump, branch, mem_write, alu_src, reg_write, reg_dst, mem_to_reg}
        case (ctrl_word)
            7'b0000110: begin enc_opcode = OP_RTYPE; enc_valid = 1'b1; end
            7'b0001100: begin enc_opcode = OP_ADDI;  enc_valid = 1'b1; end
            7'b0001101: begin enc_opcode = OP_LW;    enc_valid = 1'b1; end
            7'b0011000: begin enc_opcode = OP_SW;    enc_valid = 1'b1; end
            7'b0100000: begin enc_opcode = OP_BEQ;   enc_valid = 1'b1; end
            7'b1000000: begin enc_opcode = OP_JMP;   enc_valid = 1'b1; end
            7'b0000000: begin enc_opcode = 3'b110;   enc_valid = 1'b0; end
            default:    begin enc_opcode = 3'b111;   enc_valid = 1'b0; end
        endcase
    end

endmodule

// File: rtl/ctrl_sweep_sequencer.sv
// Sweeps every opcode into the control decoder, waits SETTLE_CYCLES, samples and
// checks the returned word; start-to-done is 8*(SETTLE_CYCLES+2)+1 cycles.
module ctrl_sweep_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int OPC_W         = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [OPC_W-1:0]  opcode,
    input  logic [CTRL_W-1:0] ctrl_word,
    output logic              busy,
    output logic              done,
    output logic [OPC_W-1:0]  enc_opcode,
    output logic              enc_valid,
    output logic [3:0]        err_count,
    output logic [OPC_W-1:0]  first_err_opcode,
    output logic              err_seen
);

    localparam logic [3:0]       SETTLE_RELOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [OPC_W-1:0] OPC_LAST      = '1;

    sweep_state_e     state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [OPC_W-1:0] opcode_q, opcode_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [OPC_W-1:0] enc_opcode_q, enc_opcode_d;
    logic             enc_valid_q, enc_valid_d;
    logic [3:0]       err_count_q, err_count_d;
    logic [OPC_W-1:0] first_err_q, first_err_d;
    logic             err_seen_q, err_seen_d;

    logic [2:0]       enc_op;
    logic             enc_vld;
    logic             mismatch;

    ctrl_word_encoder u_enc (
        .ctrl_word  (ctrl_word),
        .enc_opcode (enc_op),
        .enc_valid  (enc_vld)
    );

    assign mismatch = (ctrl_word != expected_word(3'(opcode_q)));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        opcode_d     = opcode_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        enc_opcode_d = enc_opcode_q;
        enc_valid_d  = enc_valid_q;
        err_count_d  = err_count_q;
        first_err_d  = first_err_q;
        err_seen_d   = err_seen_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    err_count_d = '0;
                    err_seen_d  = 1'b0;
                    first_err_d = '0;
                    opcode_d    = '0;
                    busy_d      = 1'b1;
                    cnt_d       = SETTLE_RELOAD;
                    state_d     = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == 4'd0) state_d = ST_SAMPLE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            ST_SAMPLE: begin
                enc_opcode_d = OPC_W'(enc_op);
                enc_valid_d  = enc_vld;
                if (mismatch) begin
                    if (err_count_q != 4'd15) err_count_d = err_count_q + 4'd1;
                    if (!err_seen_q) begin
                        first_err_d = opcode_q;
                        err_seen_d  = 1'b1;
                    end
                end
                state_d = ST_NEXT;
            end
            ST_NEXT: begin
                if (opcode_q == OPC_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    opcode_d = opcode_q + OPC_W'(1);
                    cnt_d    = SETTLE_RELOAD;
                    state_d  = ST_SETTLE;
                end
            end
            ST_DONE: begin
                done_d   = 1'b1;
                busy_d   = 1'b0;
                opcode_d = '0;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            opcode_q     <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            enc_opcode_q <= '0;
            enc_valid_q  <= 1'b0;
            err_count_q  <= '0;
            first_err_q  <= '0;
            err_seen_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            opcode_q     <= opcode_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            enc_opcode_q <= enc_opcode_d;
            enc_valid_q  <= enc_valid_d;
            err_count_q  <= err_count_d;
            first_err_q  <= first_err_d;
            err_seen_q   <= err_seen_d;
        end
    end

    assign opcode           = opcode_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign enc_opcode       = enc_opcode_q;
    assign enc_valid        = enc_valid_q;
    assign err_count        = err_count_q;
    assign first_err_opcode = first_err_q;
    assign err_seen         = err_seen_q;

endmodule

// File: tb/tb_ctrl_sweep_sequencer.sv
// Directed bench: two sequencers (settle 4 and settle 1) driven by a behavioural
// control decoder whose fault mode selects correct, lw-fault, stuck-zero or stuck-ones words.
module tb_ctrl_sweep_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_a, start_b;
    logic [2:0] opcode_a, opcode_b;
    logic [6:0] ctrl_word_a, ctrl_word_b;
    logic       busy_a, busy_b, done_a, done_b;
    logic [2:0] enc_opcode_a, enc_opcode_b;
    logic       enc_valid_a, enc_valid_b;
    logic [3:0] err_count_a, err_count_b;
    logic [2:0] first_err_a, first_err_b;
    logic       err_seen_a, err_seen_b;
    int         mode;
    int         n_pass = 0;
    int         n_total = 0;

    always #5 clk = ~clk;

    ctrl_sweep_sequencer #(.SETTLE_CYCLES(4), .OPC_W(3)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .opcode(opcode_a),
        .ctrl_word(ctrl_word_a), .busy(busy_a), .done(done_a),
        .enc_opcode(enc_opcode_a), .enc_valid(enc_valid_a), .err_count(err_count_a),
        .first_err_opcode(first_err_a), .err_seen(err_seen_a)
    );

    ctrl_sweep_sequencer #(.SETTLE_CYCLES(1), .OPC_W(3)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .opcode(opcode_b),
        .ctrl_word(ctrl_word_b), .busy(busy_b), .done(done_b),
        .enc_opcode(enc_opcode_b), .enc_valid(enc_valid_b), .err_count(err_count_b),
        .first_err_opcode(first_err_b), .err_seen(err_seen_b)
    );

    // mode 0: correct, 1: lw drops mem_to_reg, 2: stuck at zero, 3: stuck at all ones
    function automatic logic [6:0] decode(input logic [2:0] op, input int m);
        logic [6:0] w;
        case (op)
            3'd0:    w = 7'b0000110;
            3'd1:    w = 7'b0001100;
            3'd2:    w = 7'b0001101;
            3'd3:    w = 7'b0011000;
            3'd4:    w = 7'b0100000;
            3'd5:    w = 7'b1000000;
            default: w = 7'b0000000;
        endcase
        if (m == 1 && op == 3'd2) w = 7'b0001100;
        if (m == 2) w = 7'b0000000;
        if (m == 3) w = 7'b1111111;
        return w;
    endfunction

    always_comb ctrl_word_a = decode(opcode_a, mode);
    always_comb ctrl_word_b = decode(opcode_b, mode);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Starts a sweep on instance a (which=0) or b (which=1) and watches it for
    // `window` cycles; restart_at>0 pulses start again at that cycle.
    task automatic do_sweep(input int which, input int restart_at, input int window,
                            output int done_cyc, output int done_cnt, output logic busy1);
        done_cyc = 0;
        done_cnt = 0;
        busy1    = 1'b0;
        @(posedge clk); #1;
        if (which == 0) start_a = 1'b1; else start_b = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
        for (int n = 1; n <= window; n++) begin
            @(posedge clk); #1;
            start_a = (which == 0 && restart_at == n);
            if (n == 1) busy1 = (which == 0) ? busy_a : busy_b;
            if ((which == 0) ? done_a : done_b) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = n;
            end
        end
        start_a = 1'b0;
    endtask

    initial begin
        int   dc, dn;
        logic b1;
        int   found;
        reset   = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        mode    = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_opcode", 32'(opcode_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_enc", 32'({enc_opcode_a, enc_valid_a}), 32'd0);
        check("rst_err", 32'({err_count_a, first_err_a, err_seen_a}), 32'd0);
        reset = 1'b0;

        // Correct decoder
        mode = 0;
        do_sweep(0, 0, 60, dc, dn, b1);
        check("ok_busy_after_start", 32'(b1), 32'd1);
        check("ok_done_cycle", 32'(dc), 32'd49);
        check("ok_done_pulses", 32'(dn), 32'd1);
        check("ok_err_count", 32'(err_count_a), 32'd0);
        check("ok_err_seen", 32'(err_seen_a), 32'd0);
        check("ok_enc_opcode", 32'(enc_opcode_a), 32'd6);
        check("ok_enc_valid", 32'(enc_valid_a), 32'd0);
        check("ok_busy_end", 32'(busy_a), 32'd0);
        check("ok_opcode_end", 32'(opcode_a), 32'd0);

        // lw loses mem_to_reg
        mode = 1;
        do_sweep(0, 0, 60, dc, dn, b1);
        check("lw_err_count", 32'(err_count_a), 32'd1);
        check("lw_first_err", 32'(first_err_a), 32'd2);
        check("lw_err_seen", 32'(err_seen_a), 32'd1);

        // Stuck at zero: reserved opcodes are not errors
        mode = 2;
        do_sweep(0, 0, 60, dc, dn, b1);
        check("zero_err_count", 32'(err_count_a), 32'd6);
        check("zero_first_err", 32'(first_err_a), 32'd0);
        check("zero_enc", 32'({enc_opcode_a, enc_valid_a}), 32'({3'b110, 1'b0}));

        // Reset while settling opcode 011
        mode = 2;
        @(posedge clk); #1;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        found = 0;
        for (int n = 0; n < 40 && found == 0; n++) begin
            if (opcode_a == 3'd3) found = 1;
            else begin @(posedge clk); #1; end
        end
        check("mid_reach_op3", 32'(found), 32'd1);
        check("mid_err_before", 32'(err_count_a), 32'd3);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("mid_opcode", 32'(opcode_a), 32'd0);
        check("mid_busy", 32'(busy_a), 32'd0);
        check("mid_err_cleared", 32'({err_count_a, err_seen_a}), 32'd0);
        dn = 0;
        for (int n = 0; n < 60; n++) begin
            if (done_a) dn++;
            @(posedge clk); #1;
        end
        check("mid_no_done", 32'(dn), 32'd0);
        mode = 0;
        do_sweep(0, 0, 60, dc, dn, b1);
        check("mid_restart_done", 32'(dc), 32'd49);
        check("mid_restart_err", 32'(err_count_a), 32'd0);

        // Second start mid-sweep is ignored
        mode = 1;
        do_sweep(0, 10, 60, dc, dn, b1);
        check("restart_done_cycle", 32'(dc), 32'd49);
        check("restart_done_pulses", 32'(dn), 32'd1);
        check("restart_err_count", 32'(err_count_a), 32'd1);

        // Stuck at ones, settle 1
        mode = 3;
        do_sweep(1, 0, 35, dc, dn, b1);
        check("ones_done_cycle", 32'(dc), 32'd25);
        check("ones_done_pulses", 32'(dn), 32'd1);
        check("ones_err_count", 32'(err_count_b), 32'd8);
        check("ones_enc", 32'({enc_opcode_b, enc_valid_b}), 32'({3'b111, 1'b0}));
        check("ones_first_err", 32'({first_err_b, err_seen_b}), 32'({3'b000, 1'b1}));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
